// File: rtl/mxint8_block_dequant_ser.sv
// -----------------------------------------------------------------------------
// mxint8_block_dequant_ser
//
// Takes one MXINT8 block (E8M0 shared scale plus BLOCK_SIZE INT8 elements) on a
// valid/ready handshake. Each element is dequantized to IEEE FP32 and streamed
// out one per cycle on a second valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   i_blk_valid           input block valid
//   o_blk_ready           block can be accepted this cycle
//   i_scale               shared E8M0 scale (bias 127, all-ones = NaN)
//   i_mxint8_elements     BLOCK_SIZE elements, two's complement, 6 fraction bits
//   o_valid / i_ready     output element handshake
//   o_float32             dequantized FP32 value of element o_index
//   o_index               element index within the block
//   o_last                high on the final element of the block
//   o_overflow            result saturated to +/-Inf
//   o_underflow           nonzero element flushed to +/-0
//   o_nan                 scale was all ones; result is the canonical quiet NaN
// -----------------------------------------------------------------------------
module mxint8_block_dequant_ser #(
   parameter int BLOCK_SIZE  = 32,
   parameter int ELEM_WIDTH  = 8,
   parameter int SCALE_WIDTH = 8,
   localparam int IDX_W      = $clog2(BLOCK_SIZE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_blk_valid,
   output logic                   o_blk_ready,
   input  logic [SCALE_WIDTH-1:0] i_scale,
   input  logic [ELEM_WIDTH-1:0]  i_mxint8_elements [BLOCK_SIZE],
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [31:0]            o_float32,
   output logic [IDX_W-1:0]       o_index,
   output logic                   o_last,
   output logic                   o_overflow,
   output logic                   o_underflow,
   output logic                   o_nan
);

   localparam int FRAC_BITS = ELEM_WIDTH - 2;          // 1 sign/integer bit + fraction
   localparam int MAG_W     = ELEM_WIDTH + 1;          // magnitude of the most negative code fits
   localparam int P_W       = $clog2(MAG_W);
   localparam int EXP_W     = SCALE_WIDTH + 4;         // signed, wide enough for s + p - FRAC_BITS

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic [SCALE_WIDTH-1:0]  scale_reg;
   logic [ELEM_WIDTH-1:0]   elem_reg [BLOCK_SIZE];
   logic                    blk_accept;
   logic                    at_last;

   // ---------------------------------------------------------------- buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          scale_reg <= '0;
      else if (blk_accept) scale_reg <= i_scale;
   end

   generate
      for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          elem_reg[gi] <= '0;
            else if (blk_accept) elem_reg[gi] <= i_mxint8_elements[gi];
         end
      end
   endgenerate

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   assign at_last = (idx_reg == IDX_W'(BLOCK_SIZE - 1));

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      o_valid     = 1'b0;
      o_blk_ready = 1'b0;
      case (state_reg)
         IDLE: begin
            o_blk_ready = 1'b1;
            if (i_blk_valid) begin
               state_next = EMIT;
               idx_next   = '0;
            end
         end
         EMIT: begin
            o_valid = 1'b1;
            // The final beat frees the buffer, so a new block can land on the same edge.
            o_blk_ready = at_last & i_ready;
            if (i_ready) begin
               if (at_last) begin
                  idx_next   = '0;
                  state_next = i_blk_valid ? EMIT : IDLE;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   assign blk_accept = i_blk_valid & o_blk_ready;

   // ------------------------------------------------------------ conversion
   logic [ELEM_WIDTH-1:0]   cur_elem;
   logic [MAG_W-1:0]        ext;
   logic [MAG_W-1:0]        mag;
   logic [P_W-1:0]          lead;
   logic signed [EXP_W-1:0] exp_val;
   logic [31:0]             aligned;

   assign cur_elem = elem_reg[idx_reg];

   always_comb begin
      ext  = {cur_elem[ELEM_WIDTH-1], cur_elem};
      mag  = ext[MAG_W-1] ? (~ext + MAG_W'(1)) : ext;
      lead = '0;
      for (int i = 0; i < MAG_W; i++) begin
         if (mag[i]) lead = P_W'(i);
      end
      exp_val = EXP_W'(scale_reg) + EXP_W'(lead) - EXP_W'(FRAC_BITS);
      // Shift the leading one to bit 23 so the bits below it form the mantissa.
      aligned = 32'(mag) << (5'd23 - 5'(lead));
   end

   always_comb begin
      o_float32   = '0;
      o_overflow  = 1'b0;
      o_underflow = 1'b0;
      o_nan       = 1'b0;
      if (state_reg == EMIT) begin
         if (&scale_reg) begin
            o_float32 = 32'h7FC0_0000;
            o_nan     = 1'b1;
         end else if (cur_elem != '0) begin
            if (exp_val >= $signed(EXP_W'(255))) begin
               o_float32  = {cur_elem[ELEM_WIDTH-1], 8'hFF, 23'b0};
               o_overflow = 1'b1;
            end else if (exp_val <= $signed(EXP_W'(0))) begin
               o_float32   = {cur_elem[ELEM_WIDTH-1], 31'b0};
               o_underflow = 1'b1;
            end else begin
               o_float32 = {cur_elem[ELEM_WIDTH-1], exp_val[7:0], aligned[22:0]};
            end
         end
      end
   end

   assign o_index = idx_reg;
   assign o_last  = (state_reg == EMIT) & at_last;

endmodule

// File: tb/tb_mxint8_block_dequant_ser.sv
module tb_mxint8_block_dequant_ser;

   localparam int BS = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_blk_valid;
   logic        o_blk_ready;
   logic [7:0]  i_scale;
   logic [7:0]  elems_drv [BS];
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_float32;
   logic [4:0]  o_index;
   logic        o_last;
   logic        o_overflow;
   logic        o_underflow;
   logic        o_nan;

   mxint8_block_dequant_ser dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_blk_valid      (i_blk_valid),
      .o_blk_ready      (o_blk_ready),
      .i_scale          (i_scale),
      .i_mxint8_elements(elems_drv),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_float32        (o_float32),
      .o_index          (o_index),
      .o_last           (o_last),
      .o_overflow       (o_overflow),
      .o_underflow      (o_underflow),
      .o_nan            (o_nan)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Block currently expected on the output, and the block queued behind it.
   logic [7:0]  exp_s;
   logic [7:0]  exp_e [BS];
   logic [7:0]  nxt_s;
   logic [7:0]  nxt_e [BS];
   logic [31:0] obs_f  [BS];
   logic [2:0]  obs_fl [BS];   // {overflow, underflow, nan}

   typedef struct packed {
      logic [31:0] f;
      logic        ov;
      logic        un;
      logic        nan;
   } res_t;

   // Reference: real value e/64 * 2^(s-127), encoded via the double-precision
   // bit pattern and re-biased to single precision.
   function automatic res_t ref_conv(input logic [7:0] e, input logic [7:0] s);
      res_t        r;
      real         v;
      int          ex;
      logic [63:0] b;
      r = '0;
      if (s == 8'hFF) begin
         r.f   = 32'h7FC0_0000;
         r.nan = 1'b1;
         return r;
      end
      if (e == 8'h00) return r;
      v  = real'($signed(e)) / 64.0;
      ex = int'(s) - 127;
      if (ex > 0) repeat (ex) v = v * 2.0;
      else        repeat (-ex) v = v / 2.0;
      b  = $realtobits(v);
      ex = int'(b[62:52]) - 1023 + 127;
      if (ex >= 255) begin
         r.f  = {b[63], 8'hFF, 23'b0};
         r.ov = 1'b1;
      end else if (ex <= 0) begin
         r.f  = {b[63], 31'b0};
         r.un = 1'b1;
      end else begin
         r.f = {b[63], ex[7:0], b[51:29]};
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rand_block();
      case ($urandom_range(0, 2))
         0:       exp_s = 8'($urandom_range(0, 12));
         1:       exp_s = 8'($urandom_range(115, 140));
         default: exp_s = 8'($urandom_range(240, 255));
      endcase
      for (int i = 0; i < BS; i++) begin
         case ($urandom_range(0, 7))
            0:       exp_e[i] = 8'h00;
            1:       exp_e[i] = 8'h80;
            default: exp_e[i] = 8'($urandom);
         endcase
      end
   endtask

   // Entered at a falling edge with the DUT idle; leaves at the falling edge
   // after the accepting rising edge, with the input ports scrambled.
   task automatic start_block();
      i_blk_valid = 1'b1;
      i_scale     = exp_s;
      elems_drv   = exp_e;
      #1 chk("blk_ready_idle", 32'(o_blk_ready), 32'd1);
      @(negedge clk);
      i_blk_valid = 1'b0;
      i_scale     = 8'($urandom);
      for (int i = 0; i < BS; i++) elems_drv[i] = 8'($urandom);
   endtask

   // mode 0: always ready, 1: random ready, 2: stall twice at element 5.
   task automatic stream(input int mode, input bit chain, input int stop_at);
      int   k = 0;
      int   guard = 0;
      int   stall = 0;
      res_t r;
      while (k < BS && guard < 1000) begin
         if (k == stop_at) return;
         case (mode)
            1:       i_ready = 1'($urandom_range(0, 1));
            2:       if (k == 5 && stall < 2) begin i_ready = 1'b0; stall++; end
                     else i_ready = 1'b1;
            default: i_ready = 1'b1;
         endcase
         if (chain && k == BS - 1) begin
            i_ready     = 1'b1;
            i_blk_valid = 1'b1;
            i_scale     = nxt_s;
            elems_drv   = nxt_e;
         end
         #1;
         r = ref_conv(exp_e[k], exp_s);
         chk($sformatf("valid[%0d]", k), 32'(o_valid), 32'd1);
         chk($sformatf("index[%0d]", k), 32'(o_index), k);
         chk($sformatf("float[%0d] e=%h s=%h", k, exp_e[k], exp_s), o_float32, r.f);
         chk($sformatf("last[%0d]", k), 32'(o_last), 32'(k == BS - 1));
         chk($sformatf("flags[%0d]", k), 32'({o_overflow, o_underflow, o_nan}),
             32'({r.ov, r.un, r.nan}));
         if (chain && k == BS - 1) chk("blk_ready_last_beat", 32'(o_blk_ready), 32'd1);
         obs_f[k]  = o_float32;
         obs_fl[k] = {o_overflow, o_underflow, o_nan};
         @(negedge clk);
         if (i_ready) k++;
         guard++;
      end
      chk("beats_delivered", k, BS);
      if (chain) begin
         i_blk_valid = 1'b0;
         exp_s       = nxt_s;
         exp_e       = nxt_e;
      end else begin
         #1;
         chk("idle_valid", 32'(o_valid), 32'd0);
         chk("idle_float", o_float32, 32'd0);
         chk("idle_flags", 32'({o_overflow, o_underflow, o_nan}), 32'd0);
         chk("idle_blk_ready", 32'(o_blk_ready), 32'd1);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      i_blk_valid = 1'b0;
      i_ready     = 1'b0;
      i_scale     = '0;
      for (int i = 0; i < BS; i++) elems_drv[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_float", o_float32, 32'd0);
      chk("rst_index", 32'(o_index), 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      chk("rst_flags", 32'({o_overflow, o_underflow, o_nan}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_blk_ready", 32'(o_blk_ready), 32'd1);

      // All ones at unit scale
      exp_s = 8'd127;
      for (int i = 0; i < BS; i++) exp_e[i] = 8'h40;
      start_block();
      stream(0, 1'b0, -1);
      chk("t1_beat0", obs_f[0], 32'h3F80_0000);
      chk("t1_beat31", obs_f[31], 32'h3F80_0000);

      // Signed and fractional values
      exp_e[0] = 8'hC0; exp_e[1] = 8'h80; exp_e[2] = 8'h60; exp_e[3] = 8'h01;
      start_block();
      stream(0, 1'b0, -1);
      chk("t2_neg_one", obs_f[0], 32'hBF80_0000);
      chk("t2_neg_two", obs_f[1], 32'hC000_0000);
      chk("t2_one_half", obs_f[2], 32'h3FC0_0000);
      chk("t2_lsb", obs_f[3], 32'h3C80_0000);

      // Overflow, underflow, NaN
      exp_s = 8'd254; exp_e[0] = 8'h80;
      start_block();
      stream(0, 1'b0, -1);
      chk("t3_ovf_val", obs_f[0], 32'hFF80_0000);
      chk("t3_ovf_flag", 32'(obs_fl[0]), 32'b100);
      exp_s = 8'd0; exp_e[0] = 8'h01;
      start_block();
      stream(0, 1'b0, -1);
      chk("t3_unf_val", obs_f[0], 32'h0000_0000);
      chk("t3_unf_flag", 32'(obs_fl[0]), 32'b010);
      exp_s = 8'hFF;
      start_block();
      stream(0, 1'b0, -1);
      chk("t3_nan_val", obs_f[7], 32'h7FC0_0000);
      chk("t3_nan_flag", 32'(obs_fl[7]), 32'b001);

      // Backpressure at element 5
      rand_block();
      start_block();
      stream(2, 1'b0, -1);

      // Back-to-back blocks with no bubble
      rand_block();
      nxt_s = exp_s; nxt_e = exp_e;
      rand_block();
      start_block();
      stream(0, 1'b1, -1);
      stream(1, 1'b0, -1);

      // Reset in the middle of a block
      rand_block();
      start_block();
      stream(0, 1'b0, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_float", o_float32, 32'd0);
      chk("midrst_index", 32'(o_index), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_blk_ready", 32'(o_blk_ready), 32'd1);
      chk("midrst_still_idle", 32'(o_valid), 32'd0);
      @(negedge clk);

      // Randomized blocks, some chained, random backpressure
      for (int t = 0; t < 10; t++) begin
         rand_block();
         start_block();
         stream(1, 1'b0, -1);
      end
      for (int t = 0; t < 4; t++) begin
         rand_block();
         nxt_s = exp_s; nxt_e = exp_e;
         rand_block();
         start_block();
         stream(1, 1'b1, -1);
         stream(1, 1'b0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
